// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the fetched instruction and reads the register file.
// The result is captured into a valid/ready output register, with load-use stalling and flush.
module decode_stage #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned REG_W       = $clog2(NUM_REGS),
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [XLEN-1:0]        in_pc,
    output logic [REG_W-1:0]       rf_rs1_addr,
    output logic [REG_W-1:0]       rf_rs2_addr,
    input  logic [XLEN-1:0]        rf_rs1_data,
    input  logic [XLEN-1:0]        rf_rs2_data,
    input  logic                   ex_valid,
    input  logic                   ex_is_load,
    input  logic [REG_W-1:0]       ex_rd,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [6:0]             out_opcode,
    output logic [2:0]             out_funct3,
    output logic [6:0]             out_funct7,
    output logic [REG_W-1:0]       out_rd,
    output logic [REG_W-1:0]       out_rs1,
    output logic [REG_W-1:0]       out_rs2,
    output logic [XLEN-1:0]        out_imm,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_reg_a,
    output logic [XLEN-1:0]        out_reg_b,
    output logic                   out_illegal,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  reg_a;
        logic [XLEN-1:0]  reg_b;
        logic             illegal;
    } bundle_t;

    logic [4:0]  rd_raw;
    logic [4:0]  rs1_raw;
    logic [4:0]  rs2_raw;
    logic        uses_rd;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        known_op;
    logic        bad_funct;
    logic        bad_reg;
    logic [31:0] imm32;
    logic        hazard;
    logic        accept;
    bundle_t     dec;

    bundle_t                bundle_d, bundle_q;
    logic                   out_valid_d, out_valid_q;
    logic [STALL_CNT_W-1:0] stall_d, stall_q;

    always_comb begin
        rd_raw    = in_instr[11:7];
        rs1_raw   = in_instr[19:15];
        rs2_raw   = in_instr[24:20];
        uses_rd   = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        known_op  = 1'b1;
        bad_funct = 1'b0;
        imm32     = '0;
        case (opcode_e'(in_instr[6:0]))
            OPC_LUI, OPC_AUIPC: begin
                uses_rd = 1'b1;
                imm32   = {in_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                uses_rd = 1'b1;
                imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
                imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OPC_OP: begin
                uses_rd   = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                bad_funct = !((in_instr[31:25] == 7'h00) ||
                              ((in_instr[31:25] == 7'h20) &&
                               ((in_instr[14:12] == 3'b000) || (in_instr[14:12] == 3'b101))));
            end
            default: known_op = 1'b0;
        endcase

        // Index check uses the raw 5-bit fields, before truncation to REG_W
        bad_reg = (NUM_REGS == 16) &&
                  ((uses_rd & rd_raw[4]) | (uses_rs1 & rs1_raw[4]) | (uses_rs2 & rs2_raw[4]));

        dec.opcode  = in_instr[6:0];
        dec.funct3  = in_instr[14:12];
        dec.funct7  = in_instr[31:25];
        dec.rd      = uses_rd  ? rd_raw[REG_W-1:0]  : '0;
        dec.rs1     = uses_rs1 ? rs1_raw[REG_W-1:0] : '0;
        dec.rs2     = uses_rs2 ? rs2_raw[REG_W-1:0] : '0;
        dec.imm     = XLEN'($signed(imm32));
        dec.pc      = in_pc;
        dec.reg_a   = rf_rs1_data;
        dec.reg_b   = rf_rs2_data;
        dec.illegal = !known_op | bad_funct | bad_reg;
    end

    assign rf_rs1_addr = dec.rs1;
    assign rf_rs2_addr = dec.rs2;

    assign hazard = ex_valid & ex_is_load & (ex_rd != '0) &
                    ((uses_rs1 & (dec.rs1 == ex_rd)) | (uses_rs2 & (dec.rs2 == ex_rd)));
    assign in_ready = !flush & !hazard & (!out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        stall_d     = stall_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (in_valid && hazard && !flush && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q    <= '0;
            out_valid_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            bundle_q    <= bundle_d;
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_opcode  = bundle_q.opcode;
    assign out_funct3  = bundle_q.funct3;
    assign out_funct7  = bundle_q.funct7;
    assign out_rd      = bundle_q.rd;
    assign out_rs1     = bundle_q.rs1;
    assign out_rs2     = bundle_q.rs2;
    assign out_imm     = bundle_q.imm;
    assign out_pc      = bundle_q.pc;
    assign out_reg_a   = bundle_q.reg_a;
    assign out_reg_b   = bundle_q.reg_b;
    assign out_illegal = bundle_q.illegal;
    assign stall_count = stall_q;

endmodule
